// File: rtl/instr_mem_pipelined_if.sv
// Bus bundle for the pipelined instruction memory: fetch request/response
// signals and the streaming load port. The master side is the pipeline /
// loader, the slave side is the memory.
//
// Handshake: a fetch transfers on a rising edge when fetch_valid and
// fetch_ready are both high and neither stall nor flush is asserted; the
// response appears on instr/instr_valid one cycle later. fetch_ready is low
// for as long as load_mode is high. The load port has no back-pressure: every
// load_valid cycle in load_mode is consumed (written or counted as overflow).
interface instr_mem_pipelined_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 1024
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  fetch_valid;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  stall;
    logic                  flush;
    logic                  fetch_ready;
    logic [DATA_WIDTH-1:0] instr;
    logic                  instr_valid;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic                  fault_misaligned;
    logic                  fault_range;
    logic                  load_mode;
    logic                  load_start;
    logic [ADDR_WIDTH-1:0] load_base;
    logic                  load_valid;
    logic [DATA_WIDTH-1:0] load_data;
    logic [CNT_W-1:0]      load_count;
    logic                  load_overflow;

    modport master (
        output fetch_valid, pc, stall, flush,
        output load_mode, load_start, load_base, load_valid, load_data,
        input  fetch_ready, instr, instr_valid, instr_pc,
        input  fault_misaligned, fault_range, load_count, load_overflow
    );

    modport slave (
        input  fetch_valid, pc, stall, flush,
        input  load_mode, load_start, load_base, load_valid, load_data,
        output fetch_ready, instr, instr_valid, instr_pc,
        output fault_misaligned, fault_range, load_count, load_overflow
    );
endinterface

// File: rtl/instr_mem_pipelined.sv
// Loadable instruction memory with a registered one-cycle fetch port.
// Words are streamed in through an auto-incrementing load pointer while
// load_mode is high; fetches are byte-addressed, word-indexed (pc >> 2) and
// report misaligned and out-of-range requests instead of wrapping/rounding.
module instr_mem_pipelined #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 1024,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
    input logic                  i_clock,
    input logic                  i_reset,
    instr_mem_pipelined_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Contents are intentionally not reset: a reset must not wipe a program.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_overflow;

    logic [DATA_WIDTH-1:0] r_instr;
    logic                  r_instr_valid;
    logic [ADDR_WIDTH-1:0] r_instr_pc;
    logic                  r_fault_mis;
    logic                  r_fault_rng;

    // Fetch-side decode: full-width index so upper bits are range-checked.
    logic [ADDR_WIDTH-1:0] w_fetch_idx;
    logic                  w_mis;
    logic                  w_rng;
    logic [DATA_WIDTH-1:0] w_rd_word;

    assign w_fetch_idx = bus.pc >> 2;
    assign w_mis       = (bus.pc[1:0] != 2'b00);
    assign w_rng       = (w_fetch_idx >= ADDR_WIDTH'(DEPTH));
    assign w_rd_word   = r_mem[w_fetch_idx[IDX_W-1:0]];

    // Load-side decode: a same-cycle load_start redirects the write to the new base.
    logic [ADDR_WIDTH-1:0] w_ptr_eff;
    logic                  w_ptr_ok;
    logic                  w_do_write;
    logic [CNT_W-1:0]      w_count_base;
    logic                  w_unused_ok;

    assign w_ptr_eff    = bus.load_start ? (bus.load_base >> 2) : r_ptr;
    assign w_ptr_ok     = (w_ptr_eff < ADDR_WIDTH'(DEPTH));
    assign w_do_write   = !i_reset && bus.load_mode && bus.load_valid && w_ptr_ok;
    assign w_count_base = bus.load_start ? '0 : r_count;
    assign w_unused_ok  = &{1'b0, bus.load_base[1:0]};

    // Memory write port; dropped while reset is asserted.
    always_ff @(posedge i_clock) begin
        if (w_do_write) begin
            r_mem[w_ptr_eff[IDX_W-1:0]] <= bus.load_data;
        end
    end

    // Load pointer, saturating word counter and sticky overflow flag.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_ptr      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (bus.load_mode) begin
            if (bus.load_start) begin
                r_ptr      <= w_ptr_eff;
                r_count    <= '0;
                r_overflow <= 1'b0;
            end
            if (bus.load_valid) begin
                if (w_ptr_ok) begin
                    r_ptr <= w_ptr_eff + 1'b1;
                    if (w_count_base != CNT_W'(DEPTH)) begin
                        r_count <= w_count_base + 1'b1;
                    end else begin
                        r_count <= w_count_base;
                    end
                end else begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    // Fetch output registers: reset > flush > load_mode > stall > fetch > idle.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_instr       <= NOP_WORD;
            r_instr_valid <= 1'b0;
            r_instr_pc    <= '0;
            r_fault_mis   <= 1'b0;
            r_fault_rng   <= 1'b0;
        end else if (bus.flush || bus.load_mode) begin
            r_instr       <= NOP_WORD;
            r_instr_valid <= 1'b0;
            r_fault_mis   <= 1'b0;
            r_fault_rng   <= 1'b0;
        end else if (bus.stall) begin
            r_instr_valid <= r_instr_valid;
        end else if (bus.fetch_valid) begin
            r_instr       <= (w_mis || w_rng) ? NOP_WORD : w_rd_word;
            r_instr_valid <= 1'b1;
            r_instr_pc    <= bus.pc;
            r_fault_mis   <= w_mis;
            r_fault_rng   <= w_rng;
        end else begin
            r_instr       <= NOP_WORD;
            r_instr_valid <= 1'b0;
            r_fault_mis   <= 1'b0;
            r_fault_rng   <= 1'b0;
        end
    end

    assign bus.fetch_ready      = !bus.load_mode;
    assign bus.instr            = r_instr;
    assign bus.instr_valid      = r_instr_valid;
    assign bus.instr_pc         = r_instr_pc;
    assign bus.fault_misaligned = r_fault_mis;
    assign bus.fault_range      = r_fault_rng;
    assign bus.load_count       = r_count;
    assign bus.load_overflow    = r_overflow;
endmodule

// File: doc/instr_mem_pipelined.md
# instr_mem_pipelined

Parametrised, loadable instruction memory for the MIPS pipeline fetch stage. Words are written through a streaming load port with an auto-incrementing pointer. Reads use a registered, one-cycle-latency fetch port with stall, flush and fault reporting. Replaces the hard-coded, combinationally read program store: contents are loaded at run time, and accesses are byte-addressed with proper word indexing.

## Interface
- DATA_WIDTH, 32, instruction word width
- ADDR_WIDTH, 32, byte-address width of pc and load_base
- DEPTH, 1024, number of instruction words
- NOP_WORD, 32'h00000000, value driven on instr when no valid instruction is present
- clock  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high
- fetch_valid  in  1  fetch request
- pc  in  ADDR_WIDTH  byte address of the request
- stall  in  1  hold the output registers
- flush  in  1  squash the output
- fetch_ready  out  1  combinational, equals !load_mode
- instr  out  DATA_WIDTH  fetched word
- instr_valid  out  1  instr and instr_pc are meaningful
- instr_pc  out  ADDR_WIDTH  pc of the word held in instr
- fault_misaligned  out  1  held word came from a pc with pc[1:0] != 0
- fault_range  out  1  held word came from a pc with (pc>>2) >= DEPTH
- load_mode  in  1  level; high disables fetch and enables the load port
- load_start  in  1  set load pointer from load_base
- load_base  in  ADDR_WIDTH  byte address for load_start
- load_valid  in  1  write load_data at the pointer
- load_data  in  DATA_WIDTH  word to write
- load_count  out  clog2(DEPTH)+1  words written since the last load_start or reset
- load_overflow  out  1  sticky: a load write fell outside 0..DEPTH-1

## Operation
- Word index is idx = pc >> 2. Index width is clog2(DEPTH); upper bits are range-checked, never truncated.
- A fetch is accepted when fetch_valid && fetch_ready && !stall && !flush.
- On an accepted fetch, the output registers take these values on the next edge:
  - instr = mem[idx], or NOP_WORD if either fault applies
  - instr_valid = 1
  - instr_pc = pc
  - fault flags set per pc
- A misaligned pc takes the fault path: it is never rounded down.
- Output register update priority, highest first:
  1. reset
  2. flush: instr = NOP_WORD, valid = 0, faults = 0, instr_pc held
  3. load_mode: same effect as flush
  4. stall: all outputs hold
  5. accepted fetch
  6. otherwise (no request): instr_valid = 0, instr = NOP_WORD
- Load port is active only while load_mode = 1; load_start and load_valid are ignored otherwise.
- load_start:
  - ptr = load_base >> 2
  - load_count = 0
  - load_overflow cleared
- load_valid:
  - if ptr < DEPTH: write mem[ptr] = load_data, ptr += 1, load_count += 1
  - else: write dropped, load_overflow = 1, ptr and count hold
- load_start and load_valid in the same cycle: the word is written at the new base (load_base>>2) and ptr becomes base+1. The same range check applies.
- Memory contents are not cleared by reset. Only the pointer, counters and outputs reset.
- Read-during-write cannot occur, because fetch is disabled in load_mode.

## Timing
- Fetch latency: 1 cycle from acceptance to instr_valid.
- Throughput: one fetch per cycle.
- fetch_ready tracks load_mode combinationally.
- A load write is visible to a fetch accepted in the first cycle after load_mode falls.
- Reset values:
  - instr = NOP_WORD
  - instr_valid = 0
  - instr_pc = 0
  - both fault flags = 0
  - ptr = 0
  - load_count = 0
  - load_overflow = 0
- Reset asserted mid-load: the pointer returns to 0 and the in-flight write is dropped.
- Reset asserted mid-stall: outputs return to reset values.
- load_count saturates at DEPTH.

## Test plan
- Load and fetch:
  - stimulus: reset; load_mode = 1; load_start with base 0; stream 8C000000, 8C010001, 03FEF020; load_mode = 0; fetch pc = 0, 4, 8 on consecutive cycles
  - response: instr = 8C000000, 8C010001, 03FEF020 with instr_valid = 1, one cycle after each request; load_count = 3
- Stall and flush:
  - stimulus: fetch pc = 4; stall 3 cycles while pc changes to 8; then flush together with a request
  - response: instr holds 8C010001 for all stall cycles; after the flush edge, instr_valid = 0 and instr = 00000000
- Faults:
  - stimulus: fetch pc = 6, then pc = 4*DEPTH
  - response:
    - pc = 6: fault_misaligned = 1, instr = NOP_WORD, instr_valid = 1, instr_pc = 6
    - pc = 4*DEPTH: fault_range = 1, instr = NOP_WORD
- Load overflow:
  - stimulus: load_start with base 4*(DEPTH-1); write 2 words
  - response: mem[DEPTH-1] is written; load_overflow = 1; load_count = 1
  - follow-up: load_start clears load_overflow
- Simultaneous start and write:
  - stimulus: load_start with base 0x10 in the same cycle as load_valid with data AC210000
  - response: a fetch of pc = 0x10 returns AC210000; load_count = 1
- Reset mid-operation:
  - stimulus: assert reset during a stall with instr_valid = 1
  - response: instr_valid = 0, instr = NOP_WORD, load_count = 0; previously loaded words still fetch correctly after reset
